// File: rtl/pixel_readout_ctrl.sv
// pixel_readout_ctrl: 2x2 pixel array frame sequencer, conversion-count bus driver and valid/ready pixel streamer.
// Define GRAY_CODE_EN to drive the conversion count as Gray code and decode captured codes back to binary.
module pixel_readout_ctrl #(
  parameter int DW         = 8,
  parameter int ERASE_CYC  = 5,
  parameter int EXPOSE_CYC = 255,
  parameter int READ_CYC   = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic          busy,
  output logic          ERASE,
  output logic          RESET,
  output logic          EXPOSE,
  output logic          RAMP,
  output logic          READ1,
  output logic          READ2,
  inout  wire  [DW-1:0] pixData1,
  inout  wire  [DW-1:0] pixData2,
  inout  wire  [DW-1:0] pixData3,
  inout  wire  [DW-1:0] pixData4,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          frame_done
);
  localparam int CW = DW > 16 ? DW : 16;
  localparam logic [CW-1:0] ERASE_LAST  = CW'(ERASE_CYC - 1);
  localparam logic [CW-1:0] EXPOSE_LAST = CW'(EXPOSE_CYC - 1);
  localparam logic [CW-1:0] READ_LAST   = CW'(READ_CYC - 1);
  localparam logic [CW-1:0] CONV_LAST   = {CW{1'b1}} >> (CW - DW);

  typedef enum logic [3:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_TURN, S_RD1, S_RD2, S_DRAIN, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [DW-1:0]   pbuf_q [4];
  logic [DW-1:0]   pbuf_d [4];
  logic [DW-1:0]   code_q, code_d;
  logic            drv_q, drv_d;
  logic [7:0]      ctl_q, ctl_d;

  function automatic logic [DW-1:0] enc(input logic [DW-1:0] b);
`ifdef GRAY_CODE_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  function automatic logic [DW-1:0] dec(input logic [DW-1:0] g);
`ifdef GRAY_CODE_EN
    logic [DW-1:0] b;
    b[DW-1] = g[DW-1];
    for (int i = DW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
`else
    return g;
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    pbuf_d  = pbuf_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_ERASE;
      end
      S_ERASE: if (cnt_q == ERASE_LAST) begin
        state_d = S_EXPOSE;
        cnt_d   = '0;
      end
      S_EXPOSE: if (cnt_q == EXPOSE_LAST) begin
        state_d = S_CONVERT;
        cnt_d   = '0;
      end
      S_CONVERT: if (cnt_q == CONV_LAST) begin
        state_d = S_TURN;
        cnt_d   = '0;
      end
      S_TURN: begin
        state_d = S_RD1;
        cnt_d   = '0;
      end
      S_RD1: if (cnt_q == READ_LAST) begin
        state_d   = S_RD2;
        cnt_d     = '0;
        pbuf_d[0] = dec(pixData1);
        pbuf_d[1] = dec(pixData2);
      end
      S_RD2: if (cnt_q == READ_LAST) begin
        state_d   = S_DRAIN;
        cnt_d     = '0;
        pbuf_d[2] = dec(pixData3);
        pbuf_d[3] = dec(pixData4);
      end
      S_DRAIN: if (out_ready) begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state so every strobe is a clean flop output.
    code_d = enc(cnt_d[DW-1:0]);
    drv_d  = state_d == S_CONVERT;
    ctl_d  = {state_d != S_IDLE, state_d == S_ERASE, state_d == S_EXPOSE, state_d == S_CONVERT,
              state_d == S_RD1, state_d == S_RD2, state_d == S_DRAIN, state_d == S_DONE};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pbuf_q  <= '{default: '0};
      code_q  <= '0;
      drv_q   <= 1'b0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pbuf_q  <= pbuf_d;
      code_q  <= code_d;
      drv_q   <= drv_d;
      ctl_q   <= ctl_d;
    end
  end

  assign {busy, ERASE, EXPOSE, RAMP, READ1, READ2, out_valid, frame_done} = ctl_q;
  assign RESET    = ctl_q[6];
  assign out_data = pbuf_q[idx_q];
  assign out_idx  = idx_q;
  assign pixData1 = drv_q ? code_q : 'z;
  assign pixData2 = drv_q ? code_q : 'z;
  assign pixData3 = drv_q ? code_q : 'z;
  assign pixData4 = drv_q ? code_q : 'z;
endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// tb_pixel_readout_ctrl: randomized frames against a cycle-indexed behavioural model with a latching pixel model.
module tb_pixel_readout_ctrl;
  localparam int DW = 8, E = 5, X = 255, R = 3, N = 1 << DW;
  localparam int T_CONV = E + X + 1, T_TURN = E + X + N + 1, T_RD2 = T_TURN + 1 + R, T_DRAIN = T_RD2 + R;

  logic clk = 0, reset_n = 0, start = 0, out_ready = 0;
  logic busy, ERASE, RESET, EXPOSE, RAMP, READ1, READ2, out_valid, frame_done;
  logic [DW-1:0] out_data;
  logic [1:0] out_idx;
  wire [DW-1:0] pix1, pix2, pix3, pix4;

  pixel_readout_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy),
    .ERASE(ERASE), .RESET(RESET), .EXPOSE(EXPOSE), .RAMP(RAMP), .READ1(READ1), .READ2(READ2),
    .pixData1(pix1), .pixData2(pix2), .pixData3(pix3), .pixData4(pix4),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Phase of a frame from the cycle index t since the start edge (0 = idle).
  function automatic int ph(input int t);
    if (t == 0) return 0;
    if (t <= E) return 1;
    if (t < T_CONV) return 2;
    if (t < T_TURN) return 3;
    if (t == T_TURN) return 4;
    if (t < T_RD2) return 5;
    if (t < T_DRAIN) return 6;
    if (t == T_DRAIN) return 7;
    return 8;
  endfunction

  function automatic logic [DW-1:0] code(input int c);
    logic [DW-1:0] b;
    b = DW'(c);
`ifdef GRAY_CODE_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  int t = 0;
  logic [1:0] d_idx = 0;
  bit fresh = 1;
  logic [DW-1:0] thr [4];
  logic [DW-1:0] latched [4];
  logic [DW-1:0] log_q [$];
  logic [DW-1:0] bus_v [4];
  logic [DW-1:0] drv_val [4];
  logic [DW-1:0] prev = 0;
  logic drv_en;

  assign bus_v[0] = pix1;
  assign bus_v[1] = pix2;
  assign bus_v[2] = pix3;
  assign bus_v[3] = pix4;

  // Pixel array: drives latched codes while read, a probe value whenever the controller must be off the bus.
  always_comb begin
    drv_en = ph(t) != 3;
    for (int i = 0; i < 4; i++)
      drv_val[i] = ((ph(t) == 5 && i < 2) || (ph(t) == 6 && i >= 2)) ? latched[i] : DW'(8'h5A);
  end
  assign pix1 = drv_en ? drv_val[0] : 'z;
  assign pix2 = drv_en ? drv_val[1] : 'z;
  assign pix3 = drv_en ? drv_val[2] : 'z;
  assign pix4 = drv_en ? drv_val[3] : 'z;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t <= 0;
      d_idx <= 0;
      fresh <= 1;
    end else begin
      if (out_valid && out_ready) log_q.push_back(out_data);
      if (ph(t) == 3)
        for (int i = 0; i < 4; i++)
          if (t - T_CONV == int'(thr[i])) latched[i] <= bus_v[i];
      case (ph(t))
        0: if (start) begin t <= 1; fresh <= 0; end
        7: if (out_ready) begin d_idx <= d_idx + 2'd1; if (d_idx == 2'd3) t <= t + 1; end
        8: t <= 0;
        default: t <= t + 1;
      endcase
    end
  end

  always @(negedge clk) begin
    int p, c;
    p = ph(t);
    c = t - T_CONV;
    chk("ctl", {busy, ERASE, RESET, EXPOSE, RAMP, READ1, READ2, out_valid, frame_done},
        {p != 0, p == 1, p == 1, p == 2, p == 3, p == 5, p == 6, p == 7, p == 8});
    for (int i = 0; i < 4; i++) chk("bus", bus_v[i], p == 3 ? code(c) : drv_val[i]);
    if (p == 7) begin
      chk("idx", out_idx, d_idx);
      chk("data", out_data, thr[d_idx]);
    end
    if (fresh) begin
      chk("rst_idx", out_idx, 0);
      chk("rst_data", out_data, 0);
    end
`ifdef GRAY_CODE_EN
    if (p == 3 && c == 200) chk("bus_at_200", bus_v[0], 8'hAC);
    if (p == 3 && c > 0) chk("gray_step", $countones(bus_v[0] ^ prev), 1);
`else
    if (p == 3 && c == 200) chk("bus_at_200", bus_v[0], 8'd200);
    if (p == 3 && c > 0) chk("bin_step", DW'(bus_v[0] - prev), 1);
`endif
    prev = bus_v[0];
  end

  initial begin
    int lat, n;
    logic [DW-1:0] lit [4];
    lit = '{8'd128, 8'd102, 8'd179, 8'd204};
    thr = lit;
    latched = '{default: '0};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    reset_n = 1;
    repeat (2) @(negedge clk);

    log_q.delete();
    start = 1;
    @(negedge clk);
    start = 0;
    lat = 1;
    while (!out_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 524);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    repeat (10) @(negedge clk);
    out_ready = 1;
    n = 0;
    while (!frame_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("frame1_done", frame_done, 1);
    out_ready = 0;
    @(negedge clk);
    chk("frame1_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("frame1_byte", (i < log_q.size()) ? log_q[i] : 'x, lit[i]);

    start = 1;
    @(negedge clk);
    start = 0;
    repeat (100) @(negedge clk);
    #2 reset_n = 0;
    #1 chk("abort", {busy, ERASE, RESET, EXPOSE, RAMP, READ1, READ2, out_valid, frame_done}, 0);
    @(negedge clk);
    #2 reset_n = 1;
    repeat (600) @(negedge clk);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) thr[i] = DW'($urandom_range(0, N - 1));
      start = 1;
      n = 0;
      while (!frame_done && n < 3000) begin
        @(negedge clk);
        n++;
        start = $urandom_range(0, 3) == 0;
        out_ready = $urandom_range(0, 2) != 0;
      end
      start = 0;
      chk("frame_done", frame_done, 1);
      out_ready = 0;
      repeat (3) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
